// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    // Sequencer states: idle and accepting, stepping bits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two bits.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_add_sequencer_full_add_cell.sv
// One-bit full adder built from two half adders and an OR for the carry.
// The two half-adder carries can never both be 1, so OR is enough.
module full_add_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha_ab (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    half_adder u_ha_cin (
        .i_a (w_s1),
        .i_b (i_cin),
        .o_s (o_s),
        .o_c (w_c2)
    );

    assign o_co = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder controller. One full-add cell is stepped over
// WIDTH cycles, LSB first.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds its data stable while valid is high. On the input side,
// a/b are captured only on a transfer in IDLE. On the output side, sum/cout
// stay stable while out_valid is high and out_ready is low. in_ready and
// out_valid are never high together, so the two transfers never coincide.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("serial_add_sequencer: WIDTH must be in 1..64");
        end
    endgenerate

    sa_state_t        r_state;
    sa_state_t        w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] w_sum_sh_next;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;
    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_last;
    logic             w_transfer;

    // Shared one-bit datapath: current LSBs plus the running carry.
    full_add_cell u_cell (
        .i_a   (r_a[0]),
        .i_b   (r_b[0]),
        .i_cin (r_c),
        .o_s   (w_s),
        .o_co  (w_co)
    );

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_last     = (r_state == RUN) && (r_cnt == CNT_LAST);
    assign w_transfer = (r_state == DONE) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at bit 0.
    always_comb begin
        w_sum_sh_next            = r_sum_sh >> 1;
        w_sum_sh_next[WIDTH-1]   = w_s;
    end

    // Operand shifters, carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum_sh <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum_sh <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_c      <= w_co;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_sum_sh <= w_sum_sh_next;
        end
    end

    // Result registers: loaded on the last bit, held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_sum       <= w_sum_sh_next;
            r_cout      <= w_co;
            r_out_valid <= 1'b1;
        end else if (w_transfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sum         = r_sum;
    assign cout        = r_cout;
    assign out_valid   = r_out_valid;
    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=8 and WIDTH=1.
module tb_serial_add_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;
    logic [1:0] dbg8;

    serial_add_sequencer #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .sum         (sum8),
        .cout        (cout8),
        .busy        (busy8),
        .o_dbg_state (dbg8)
    );

    // ---------------- WIDTH=1 instance ----------------
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;
    logic [1:0] dbg1;

    serial_add_sequencer #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .a           (a1),
        .b           (b1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready1),
        .sum         (sum1),
        .cout        (cout1),
        .busy        (busy1),
        .o_dbg_state (dbg1)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (WIDTH=8) ----------------
    // One full operation: accept, latency check, optional hold in DONE,
    // optional stray input at RUN cycle 3, then the output transfer.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold,
                       input bit inject, input logic [8:0] exp);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready8, 1);
        in_valid8 = 1'b1;
        a8 = a;
        b8 = b;
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("busy_in_run", busy8, 1);
        chk("in_ready_in_run", in_ready8, 0);
        for (int i = 0; i < 7; i++) begin
            if (inject && i == 2) begin
                in_valid8 = 1'b1;
                a8 = 8'hAA;
                b8 = 8'h55;
            end
            @(negedge clk);
            in_valid8 = 1'b0;
        end
        chk("out_valid_early", out_valid8, 0);
        @(negedge clk);
        chk("out_valid_at_latency", out_valid8, 1);
        chk("result", {cout8, sum8}, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid8, 1);
            chk("hold_result", {cout8, sum8}, exp);
            chk("hold_in_ready", in_ready8, 0);
            chk("hold_busy", busy8, 1);
            chk("hold_state_done", dbg8, 2);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("out_valid_after_transfer", out_valid8, 0);
        chk("in_ready_after_transfer", in_ready8, 1);
        chk("result_kept", {cout8, sum8}, exp);
    endtask

    // ---------------- driver task (WIDTH=1) ----------------
    task automatic op1(input logic a, input logic b, input logic [1:0] exp);
        @(negedge clk);
        in_valid1 = 1'b1;
        a1 = a;
        b1 = b;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("w1_out_valid_early", out_valid1, 0);
        @(negedge clk);
        chk("w1_out_valid", out_valid1, 1);
        chk("w1_result", {cout1, sum1}, exp);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("w1_in_ready_after", in_ready1, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        bit         got;

        // Reset values
        #12;
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_state", dbg8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sums and carry-out
        op8(8'h03, 8'h05, 0, 1'b0, 9'h008);
        op8(8'hFF, 8'h01, 0, 1'b0, 9'h100);
        op8(8'hFF, 8'hFF, 0, 1'b0, 9'h1FE);

        // Result backpressure for 5 cycles
        op8(8'h3C, 8'h0F, 5, 1'b0, 9'h04B);

        // Stray input during RUN is ignored
        op8(8'h12, 8'h34, 0, 1'b1, 9'h046);
        @(negedge clk);
        chk("no_capture_busy", busy8, 0);

        // Reset in the middle of RUN abandons the operation
        @(negedge clk);
        in_valid8 = 1'b1;
        a8 = 8'h77;
        b8 = 8'h11;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum8, 0);
        chk("mid_rst_cout", cout8, 0);
        chk("mid_rst_out_valid", out_valid8, 0);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_in_ready", in_ready8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_no_out_valid", out_valid8, 0);
        chk("post_rst_in_ready", in_ready8, 1);
        op8(8'h10, 8'h20, 0, 1'b0, 9'h030);

        // WIDTH=1: all four input combinations
        op1(1'b0, 1'b0, 2'b00);
        op1(1'b0, 1'b1, 2'b01);
        op1(1'b1, 1'b0, 2'b01);
        op1(1'b1, 1'b1, 2'b10);

        // Random pairs with random result backpressure
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back({1'b0, ra} + {1'b0, rb});
            @(negedge clk);
            in_valid8 = 1'b1;
            a8 = ra;
            b8 = rb;
            @(negedge clk);
            in_valid8 = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                if (out_valid8) begin
                    out_ready8 = 1'($urandom_range(0, 1));
                    if (out_ready8) begin
                        chk("rand_result", {cout8, sum8}, exp_q.pop_front());
                        got = 1'b1;
                    end
                end
                @(negedge clk);
            end
            out_ready8 = 1'b0;
            chk("rand_timeout", got, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
